// File: rtl/calc_pkg.sv
// Shared definitions for the sequential sign-magnitude calculator:
// operation encodings on the 'sel' input and the controller state type.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDSUB = 3'd1,
    S_MUL    = 3'd2,
    S_DIV    = 3'd3,
    S_FIN    = 3'd4
  } state_t;

endpackage

// File: rtl/sm_addsub.sv
// Combinational sign-magnitude adder.
// Ports:
//   sign_a, a : first operand (sign 1 = negative, WIDTH-bit magnitude)
//   sign_b, b : second operand (caller inverts sign_b for subtraction)
//   sign, mag : result; a zero magnitude always carries sign 0
//   ovf       : magnitude carry-out (only possible when signs agree)
module sm_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             sign_a,
  input  logic [WIDTH-1:0] a,
  input  logic             sign_b,
  input  logic [WIDTH-1:0] b,
  output logic             sign,
  output logic [WIDTH-1:0] mag,
  output logic             ovf
);

  logic [WIDTH:0] sum;
  logic           sign_raw;

  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    sign_raw = sign_a;
    mag      = '0;
    ovf      = 1'b0;
    if (sign_a == sign_b) begin
      mag      = sum[WIDTH-1:0];
      ovf      = sum[WIDTH];
      sign_raw = sign_a;
    end else if (a >= b) begin
      // larger magnitude wins the sign; a == b yields zero
      mag      = a - b;
      sign_raw = sign_a;
    end else begin
      mag      = b - a;
      sign_raw = sign_b;
    end
  end

  // never emit negative zero (also covers an overflowed sum truncating to 0)
  assign sign = sign_raw & (|mag);

endmodule

// File: rtl/seq_sm_calculator.sv
// Sequential sign-magnitude calculator: add/sub in one step, multiply by
// iterative shift-add, divide by iterative restoring division.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   start, sel          : request and op (00 add, 01 sub, 10 mul, 11 div)
//   signA, A, signB, B  : sign-magnitude operands
//   busy                : operation in progress
//   done                : one-cycle pulse, results valid until next accept
//   signQ, Q            : result / quotient
//   signR, R            : remainder (divide only, else 0)
//   ovf, dbz            : magnitude overflow, divide by zero
module seq_sm_calculator
  import calc_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       sel,
  input  logic             signA,
  input  logic [WIDTH-1:0] A,
  input  logic             signB,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             signQ,
  output logic [WIDTH-1:0] Q,
  output logic             signR,
  output logic [WIDTH-1:0] R,
  output logic             ovf,
  output logic             dbz
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  state_t             state, state_nxt;
  logic [1:0]         sel_r;
  logic               sign_a_r, sign_b_r;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [CNT_W-1:0]   cnt;
  logic               dbz_pend;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem, quo;

  // a start is only taken once the previous done pulse has gone
  logic accept;
  assign accept = (state == S_IDLE) && start && !done;
  assign busy   = (state != S_IDLE) && (state != S_FIN);

  // ---------------- add/sub ----------------
  logic             as_sign, as_ovf;
  logic [WIDTH-1:0] as_mag;

  sm_addsub #(.WIDTH(WIDTH)) u_addsub (
    .sign_a (sign_a_r),
    .a      (a_r),
    .sign_b (sign_b_r ^ (sel_r == OP_SUB)),
    .b      (b_r),
    .sign   (as_sign),
    .mag    (as_mag),
    .ovf    (as_ovf)
  );

  // ---------------- shift-add multiply step ----------------
  // prod starts as {0, B}; each step adds A into the high half when the
  // current low bit is set, then shifts the whole register right by one.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_r} : '0);
    mul_next = {mul_sum, prod[WIDTH-1:1]};
  end

  // ---------------- restoring divide step ----------------
  // rem stays below B, so WIDTH bits suffice; the shifted partial
  // remainder needs one extra bit and the trial one more for the borrow.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH-1:0] rem_next, quo_next;

  always_comb begin
    div_shift = {rem, quo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_r};
    if (!div_diff[WIDTH+1]) begin
      rem_next = div_diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = div_shift[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

  // ---------------- controller ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (sel == OP_DIV && B == '0) state_nxt = S_FIN;
          else if (sel == OP_MUL)       state_nxt = S_MUL;
          else if (sel == OP_DIV)       state_nxt = S_DIV;
          else                          state_nxt = S_ADDSUB;
        end
      end
      S_ADDSUB: state_nxt = S_FIN;
      // one extra cycle after the last step before handing over to FIN
      S_MUL, S_DIV: if (cnt == LAST) state_nxt = S_FIN;
      S_FIN:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ---------------- datapath and result registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r    <= '0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      cnt      <= '0;
      dbz_pend <= 1'b0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      done     <= 1'b0;
      signQ    <= 1'b0;
      Q        <= '0;
      signR    <= 1'b0;
      R        <= '0;
      ovf      <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      done <= (state == S_FIN);
      case (state)
        S_IDLE: begin
          if (accept) begin
            sel_r    <= sel;
            sign_a_r <= signA;
            sign_b_r <= signB;
            a_r      <= A;
            b_r      <= B;
            cnt      <= '0;
            dbz_pend <= (sel == OP_DIV) && (B == '0);
            prod     <= {{WIDTH{1'b0}}, B};
            rem      <= '0;
            quo      <= A;
            ovf      <= 1'b0;
            dbz      <= 1'b0;
          end
        end
        S_MUL: begin
          if (cnt != LAST) begin
            prod <= mul_next;
            cnt  <= cnt + 1'b1;
          end
        end
        S_DIV: begin
          if (cnt != LAST) begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 1'b1;
          end
        end
        S_FIN: begin
          signR <= 1'b0;
          R     <= '0;
          ovf   <= 1'b0;
          dbz   <= 1'b0;
          if (dbz_pend) begin
            signQ <= 1'b0;
            Q     <= '0;
            dbz   <= 1'b1;
          end else begin
            case (sel_r)
              OP_MUL: begin
                Q     <= prod[WIDTH-1:0];
                ovf   <= |prod[2*WIDTH-1:WIDTH];
                signQ <= (sign_a_r ^ sign_b_r) & (|prod[WIDTH-1:0]);
              end
              OP_DIV: begin
                Q     <= quo;
                signQ <= (sign_a_r ^ sign_b_r) & (|quo);
                R     <= rem;
                signR <= sign_a_r & (|rem);
              end
              default: begin
                Q     <= as_mag;
                signQ <= as_sign;
                ovf   <= as_ovf;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sm_calculator.sv
module tb_seq_sm_calculator;

  localparam int W = 8;

  logic         clk, rst_n, start;
  logic [1:0]   sel;
  logic         signA, signB;
  logic [W-1:0] A, B;
  logic         busy, done, signQ, signR, ovf, dbz;
  logic [W-1:0] Q, R;

  int n_chk  = 0;
  int n_pass = 0;
  int lat, bcnt, dcnt;
  logic [W-1:0] q_seen;

  seq_sm_calculator #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel),
    .signA(signA), .A(A), .signB(signB), .B(B),
    .busy(busy), .done(done), .signQ(signQ), .Q(Q),
    .signR(signR), .R(R), .ovf(ovf), .dbz(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Pulse start for one edge; then count edges until done is seen,
  // sampling on negedges. lat = n means done is high after edge k+n.
  task automatic run_op(input logic [1:0] s, input logic sa, input int a,
                        input logic sb, input int b,
                        output int latency, output int busy_cycles);
    int n;
    @(negedge clk);
    sel = s; signA = sa; A = W'(a); signB = sb; B = W'(b); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0; busy_cycles = 0;
    while (!done && n < 200) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      n++;
    end
    if (!done) chk("timeout", n, -1);
    latency = n;
  endtask

  task automatic chk_res(input string tag, input int sq, input int q,
                         input int sr, input int r, input int o, input int d);
    chk({tag, ".signQ"}, int'(signQ), sq);
    chk({tag, ".Q"},     int'(Q),     q);
    chk({tag, ".signR"}, int'(signR), sr);
    chk({tag, ".R"},     int'(R),     r);
    chk({tag, ".ovf"},   int'(ovf),   o);
    chk({tag, ".dbz"},   int'(dbz),   d);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sel = 2'b00;
    signA = 1'b0; A = '0; signB = 1'b0; B = '0;
    #1;
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk_res("rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 1: -5 + 7 = 2
    run_op(2'b00, 1'b1, 5, 1'b0, 7, lat, bcnt);
    chk("add.lat", lat, 2);
    chk("add.busy", bcnt, 1);
    chk_res("add", 0, 2, 0, 0, 0, 0);
    @(negedge clk);
    chk("add.done_pulse", int'(done), 0);
    chk("add.hold", int'(Q), 2);

    // 2: -5 - 7 = -12 ; 9 - 9 = 0
    run_op(2'b01, 1'b1, 5, 1'b0, 7, lat, bcnt);
    chk("sub.lat", lat, 2);
    chk_res("sub", 1, 12, 0, 0, 0, 0);
    run_op(2'b01, 1'b0, 9, 1'b0, 9, lat, bcnt);
    chk_res("sub0", 0, 0, 0, 0, 0, 0);
    // -3 - (-3) = 0, must not be negative zero
    run_op(2'b01, 1'b1, 3, 1'b1, 3, lat, bcnt);
    chk_res("subneg0", 0, 0, 0, 0, 0, 0);
    // 4 + (-9) = -5
    run_op(2'b00, 1'b0, 4, 1'b1, 9, lat, bcnt);
    chk_res("addneg", 1, 5, 0, 0, 0, 0);

    // 3: -5 * 7 = -35 ; 20 * 20 = 400 -> 144 with ovf
    run_op(2'b10, 1'b1, 5, 1'b0, 7, lat, bcnt);
    chk("mul.lat", lat, 10);
    chk("mul.busy", bcnt, 9);
    chk_res("mul", 1, 35, 0, 0, 0, 0);
    run_op(2'b10, 1'b0, 20, 1'b0, 20, lat, bcnt);
    chk_res("mulovf", 0, 144, 0, 0, 1, 0);
    // -16 * 16 = -256 -> truncated to 0, ovf set, sign forced to 0
    run_op(2'b10, 1'b1, 16, 1'b0, 16, lat, bcnt);
    chk_res("mulz", 0, 0, 0, 0, 1, 0);
    // 255 * 255 = 65025 = 0xFE01
    run_op(2'b10, 1'b1, 255, 1'b1, 255, lat, bcnt);
    chk_res("mulmax", 0, 1, 0, 0, 1, 0);

    // 4: -35 / 6 = -5 rem -5 ; divide by zero
    run_op(2'b11, 1'b1, 35, 1'b0, 6, lat, bcnt);
    chk("div.lat", lat, 10);
    chk_res("div", 1, 5, 1, 5, 0, 0);
    run_op(2'b11, 1'b1, 35, 1'b0, 0, lat, bcnt);
    chk("dbz.lat", lat, 1);
    chk_res("dbz", 0, 0, 0, 0, 0, 1);
    // 3 / -7 = 0 rem 3, quotient sign normalised
    run_op(2'b11, 1'b0, 3, 1'b1, 7, lat, bcnt);
    chk_res("divq0", 0, 0, 0, 3, 0, 0);
    // -255 / 1 = -255 rem 0
    run_op(2'b11, 1'b1, 255, 1'b0, 1, lat, bcnt);
    chk_res("div1", 1, 255, 0, 0, 0, 0);

    // 5: 200 + 100 -> 44 with ovf
    run_op(2'b00, 1'b0, 200, 1'b0, 100, lat, bcnt);
    chk_res("addovf", 0, 44, 0, 0, 1, 0);

    // extra start while busy is ignored
    @(negedge clk);
    sel = 2'b10; signA = 1'b0; A = 8'd3; signB = 1'b0; B = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    sel = 2'b00; A = 8'd50; B = 8'd60; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0; q_seen = '0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin dcnt++; q_seen = Q; end
      @(negedge clk);
    end
    chk("busy_start.dones", dcnt, 1);
    chk("busy_start.Q", int'(q_seen), 12);

    // 6: reset in the middle of a multiply
    @(negedge clk);
    sel = 2'b10; A = 8'd3; B = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.done", int'(done), 0);
    chk_res("midrst", 0, 0, 0, 0, 0, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) dcnt++;
      @(negedge clk);
    end
    chk("midrst.nodone", dcnt, 0);
    run_op(2'b00, 1'b0, 1, 1'b0, 1, lat, bcnt);
    chk("post.lat", lat, 2);
    chk_res("post", 0, 2, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_sm_calculator.md
Name: seq_sm_calculator

Overview:
Parametrised, sequential sign-magnitude calculator. It replaces the 4-bit combinational calculator with a WIDTH-generic unit that supports add, sub, multiply and divide. Add and sub take one cycle; multiply is iterative shift-add and divide is iterative restoring. A start/busy/done handshake lets a controller FSM or UART front-end issue operations back to back. Status flags report overflow and divide-by-zero.

Parameters:
WIDTH, 8, magnitude bits of A, B, Q and R (must be >= 2).
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request; sampled only in IDLE.
sel  in  2  op: 00 add, 01 sub (A-B), 10 mul, 11 div.
signA  in  1  sign of A (1 = negative).
A  in  WIDTH  magnitude of A.
signB  in  1  sign of B.
B  in  WIDTH  magnitude of B.
busy  out  1  high from the cycle after accepted start until done.
done  out  1  one-cycle pulse; results valid from this cycle until next accepted start.
signQ  out  1  result or quotient sign.
Q  out  WIDTH  result or quotient magnitude.
signR  out  1  remainder sign (div only; otherwise 0).
R  out  WIDTH  remainder magnitude (div only; otherwise 0).
ovf  out  1  magnitude overflow (add/sub/mul).
dbz  out  1  divide by zero.

Behaviour:
- Reset (async assert, sync deassert by system): state IDLE; busy, done, signQ, Q, signR, R, ovf, dbz all 0; counter 0.
- Reset mid-operation aborts the operation with no done pulse; outputs return to 0.
- States: IDLE, ADDSUB, MUL, DIV, FIN.
- IDLE: when start=1 at edge k, latch signA/A/signB/B/sel, clear ovf/dbz, and go to ADDSUB (sel 0x), MUL, or DIV. If sel=11 and B=0, go directly to FIN with dbz=1.
- start while busy=1 or done=1 is ignored. No queueing.
- ADDSUB: sub uses effective signB' = ~signB. If signs are equal: mag = A+B (WIDTH+1 bits), sign = signA, ovf = mag[WIDTH], Q = mag[WIDTH-1:0]. If signs differ: larger magnitude minus smaller, sign taken from the larger; if equal, the result is 0. Goes to FIN at edge k+1.
- MUL: 2*WIDTH product register, one shift-add step per cycle, WIDTH steps at edges k+1..k+WIDTH, then FIN. Q = product low half; ovf = |product high half; signQ = signA^signB.
- DIV: restoring, one quotient bit per cycle, WIDTH steps at edges k+1..k+WIDTH, then FIN. Truncating division: signQ = signA^signB, signR = signA.
- dbz case: Q=0, R=0, signQ=0, signR=0, dbz=1, ovf=0.
- FIN: register results, done=1 for exactly one cycle, then IDLE.
- Latency, edge k to done high:
  - add/sub: done after edge k+2.
  - mul/div: done after edge k+WIDTH+2.
  - div by zero: done after edge k+1.
- busy = (state != IDLE) && (state != FIN).
- Zero normalisation: any zero magnitude (Q or R) forces its sign to 0; negative zero is never output. This applies even when ovf=1 and the truncated Q is 0.
- Results hold stable after done until the next accepted start.

Decomposition:
- Package calc_pkg holds:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11;
  - state encoding localparams S_IDLE, S_ADDSUB, S_MUL, S_DIV, S_FIN.
- One combinational sub-module, sm_addsub: WIDTH-param sign-magnitude adder with inputs (signA, A, signB, B), outputs (sign, mag, ovf), including zero normalisation. The top FSM owns the mul/div datapaths and the counter.

Test Plan:
1. WIDTH=8, signA=1 A=5, signB=0 B=7, sel=00, start pulse -> done 2 cycles later; signQ=0 Q=2 ovf=0.
2. Same operands, sel=01 -> signQ=1 Q=12 ovf=0. Then signA=0 A=9, signB=0 B=9, sel=01 -> Q=0 signQ=0.
3. signA=1 A=5, signB=0 B=7, sel=10 -> busy high for 9 cycles, done 10 cycles after start; signQ=1 Q=35 ovf=0. Then A=20 B=20 -> Q=144 ovf=1.
4. signA=1 A=35, signB=0 B=6, sel=11 -> signQ=1 Q=5, signR=1 R=5, dbz=0. Then B=0 -> done after 1 cycle; dbz=1 Q=0 R=0.
5. signA=0 A=200, signB=0 B=100, sel=00 -> Q=44 ovf=1. Pulse start again while the unit is busy with a mul (A=3 B=4) -> the extra start is ignored and Q=12 is returned only once.
6. Assert rst_n=0 at cycle 4 of a mul -> all outputs 0 immediately, no done pulse. After release, a fresh add (A=1 B=1) -> Q=2.
